clk_divider_bank: RTL and testbench



---
 rtl/divider_pkg.sv | 17 +
 rtl/divider_channel.sv | 105 ++++++++++
 rtl/clk_divider_bank.sv | 90 +++++++++
 tb/tb_clk_divider_bank.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// divider_pkg
// Shared types and helpers for the clk_divider_bank codebase slice.
//   mode_t    : per-channel output mode (toggle or pulse)
//   ch_sel_w  : width of a channel-select field for a given channel count
package divider_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_t;

  // A select field is never narrower than one bit, even for a single channel.
  function automatic int ch_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divider_channel.sv
// divider_channel
// One divider channel: a counter running 0..div_act, a registered divided
// output (pulse or toggle) and a one-entry shadow for glitch-free ratio/mode
// changes. The shadow is applied at the channel's wrap, on any edge while the
// channel is disabled, or on a sync edge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run enable
//   sync       : phase-align request (tied low when the sync feature is off)
//   cfg_we     : accepted config transfer for this channel
//   cfg_div    : new divide value
//   cfg_mode   : new mode (1 = pulse, 0 = toggle)
//   divided    : registered divided output
//   wrap       : registered one-cycle terminal-count strobe
//   pending    : shadow holds a config not yet applied
module divider_channel
  import divider_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_DIV  = 1,
  parameter int DEFAULT_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic             divided,
  output logic             wrap,
  output logic             pending
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam mode_t            MODE_RST = (DEFAULT_MODE != 0) ? MODE_PULSE : MODE_TOGGLE;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] shadow_div;
  mode_t            mode_act;
  mode_t            shadow_mode;
  logic             at_term;
  logic             apply;

  // Terminal count of the current period; this edge is the wrap edge.
  assign at_term = en && (cnt == div_act);

  // A transfer only happens while pending is clear, so a transfer landing on
  // a wrap edge cannot be applied by that same wrap.
  assign apply = pending && (sync || !en || at_term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      wrap    <= 1'b0;
      divided <= 1'b0;
    end else if (sync) begin
      cnt     <= '0;
      wrap    <= 1'b0;
      divided <= 1'b0;
    end else if (!en) begin
      // A partial count is discarded; a toggle output keeps its level.
      cnt  <= '0;
      wrap <= 1'b0;
      if (mode_act == MODE_PULSE) begin
        divided <= 1'b0;
      end
    end else if (at_term) begin
      // The wrap edge still obeys the old mode even if a shadow applies now.
      cnt  <= '0;
      wrap <= 1'b1;
      if (mode_act == MODE_PULSE) begin
        divided <= 1'b1;
      end else begin
        divided <= ~divided;
      end
    end else begin
      cnt  <= cnt + CNT_W'(1);
      wrap <= 1'b0;
      if (mode_act == MODE_PULSE) begin
        divided <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_act     <= DIV_RST;
      mode_act    <= MODE_RST;
      shadow_div  <= '0;
      shadow_mode <= MODE_TOGGLE;
      pending     <= 1'b0;
    end else if (cfg_we) begin
      shadow_div  <= cfg_div;
      shadow_mode <= mode_t'(cfg_mode);
      pending     <= 1'b1;
    end else if (apply) begin
      div_act  <= shadow_div;
      mode_act <= shadow_mode;
      pending  <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_divider_bank.sv
// clk_divider_bank
// Bank of NCH independent programmable clock-enable dividers with a
// valid/ready config port. Ratio and mode changes are shadowed per channel
// and take effect at that channel's wrap.
// Optional feature: define DIVIDER_BANK_SYNC_EN to add sync_in, which resets
// every channel's phase and applies pending shadows on the same edge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sync_in    : (DIVIDER_BANK_SYNC_EN only) phase-align all channels
//   en         : per-channel run enable
//   cfg_valid  : config request
//   cfg_ready  : config accept (combinational from pending and cfg_ch)
//   cfg_ch     : target channel; out-of-range values are accepted and dropped
//   cfg_div    : new divide value
//   cfg_mode   : new mode (1 = pulse, 0 = toggle)
//   divided    : registered divided outputs
//   wrap       : registered terminal-count strobes
//   pending    : per-channel shadow-waiting flags
module clk_divider_bank
  import divider_pkg::*;
#(
  parameter  int NCH          = 4,
  parameter  int CNT_W        = 16,
  parameter  int DEFAULT_DIV  = 1,
  parameter  int DEFAULT_MODE = 1,
  localparam int CH_W         = ch_sel_w(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DIVIDER_BANK_SYNC_EN
  input  logic             sync_in,
`endif
  input  logic [NCH-1:0]   en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic [NCH-1:0]   divided,
  output logic [NCH-1:0]   wrap,
  output logic [NCH-1:0]   pending
);

  logic           sync;
  logic [NCH-1:0] cfg_sel;

`ifdef DIVIDER_BANK_SYNC_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  // Ready depends only on pending and cfg_ch; a channel number with no
  // matching channel leaves ready high so the transfer is simply dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pending[i];
      end
    end
  end

  always_comb begin
    cfg_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      cfg_sel[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    divider_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_DIV  (DEFAULT_DIV),
      .DEFAULT_MODE (DEFAULT_MODE)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[g]),
      .sync     (sync),
      .cfg_we   (cfg_sel[g]),
      .cfg_div  (cfg_div),
      .cfg_mode (cfg_mode),
      .divided  (divided[g]),
      .wrap     (wrap[g]),
      .pending  (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
// tb_clk_divider_bank
// Directed, self-checking bench for clk_divider_bank (default build, NCH=4,
// CNT_W=16). Inputs change and outputs are sampled 1 time unit after each
// rising edge.
module tb_clk_divider_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_mode;
  logic [3:0]  divided;
  logic [3:0]  wrap;
  logic [3:0]  pending;
`ifdef DIVIDER_BANK_SYNC_EN
  logic        sync_in = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_divider_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DIVIDER_BANK_SYNC_EN
    .sync_in   (sync_in),
`endif
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .divided   (divided),
    .wrap      (wrap),
    .pending   (pending)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ch, input logic [15:0] div,
                               input logic mode);
    cfg_ch    = ch;
    cfg_div   = div;
    cfg_mode  = mode;
    cfg_valid = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 4'b0000;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = 16'd0;
    cfg_mode  = 1'b0;
    step(2);
    checkOutput("rst_divided", 32'(divided), 32'h0);
    checkOutput("rst_wrap", 32'(wrap), 32'h0);
    checkOutput("rst_pending", 32'(pending), 32'h0);
    checkOutput("rst_ready", 32'(cfg_ready), 32'h1);

    // Defaults: div 1, pulse on ch0
    rst_n = 1'b1;
    en    = 4'b0001;
    step(1);
    checkOutput("def_e1_divided", 32'(divided), 32'h0);
    checkOutput("def_e1_wrap", 32'(wrap), 32'h0);
    step(1);
    checkOutput("def_e2_divided", 32'(divided), 32'h1);
    checkOutput("def_e2_wrap", 32'(wrap), 32'h1);
    step(1);
    checkOutput("def_e3_divided", 32'(divided), 32'h0);
    step(1);
    checkOutput("def_e4_divided", 32'(divided), 32'h1);

    // ch1: div 4 toggle loaded while disabled
    en = 4'b0000;
    applyStimulus(2'd1, 16'd4, 1'b0);
    step(1);
    checkOutput("ch1_load_pending", 32'(pending), 32'h2);
    checkOutput("ch1_load_ready", 32'(cfg_ready), 32'h0);
    cfg_valid = 1'b0;
    step(1);
    checkOutput("ch1_apply_pending", 32'(pending), 32'h0);
    en = 4'b0010;
    step(4);
    checkOutput("ch1_e4_divided", 32'(divided), 32'h0);
    checkOutput("ch1_e4_wrap", 32'(wrap), 32'h0);
    step(1);
    checkOutput("ch1_e5_divided", 32'(divided), 32'h2);
    checkOutput("ch1_e5_wrap", 32'(wrap), 32'h2);
    step(1);
    checkOutput("ch1_e6_divided", 32'(divided), 32'h2);
    checkOutput("ch1_e6_wrap", 32'(wrap), 32'h0);
    step(4);
    checkOutput("ch1_e10_divided", 32'(divided), 32'h0);
    checkOutput("ch1_e10_wrap", 32'(wrap), 32'h2);

    // ch0: div 3, then div 7 loaded mid-period
    en = 4'b0000;
    applyStimulus(2'd0, 16'd3, 1'b1);
    step(1);
    checkOutput("ch0_load3_pending", 32'(pending), 32'h1);
    cfg_valid = 1'b0;
    step(1);
    checkOutput("ch0_apply3_pending", 32'(pending), 32'h0);
    en = 4'b0001;
    step(2);
    applyStimulus(2'd0, 16'd7, 1'b1);
    step(1);
    checkOutput("ch0_mid_pending", 32'(pending), 32'h1);
    checkOutput("ch0_mid_ready", 32'(cfg_ready), 32'h0);
    cfg_valid = 1'b0;
    step(1);
    checkOutput("ch0_e4_divided", 32'(divided), 32'h1);
    checkOutput("ch0_e4_wrap", 32'(wrap), 32'h1);
    checkOutput("ch0_e4_pending", 32'(pending), 32'h0);
    checkOutput("ch0_e4_ready", 32'(cfg_ready), 32'h1);
    step(4);
    checkOutput("ch0_e8_divided", 32'(divided), 32'h0);
    step(3);
    checkOutput("ch0_e11_divided", 32'(divided), 32'h0);
    step(1);
    checkOutput("ch0_e12_divided", 32'(divided), 32'h1);
    checkOutput("ch0_e12_wrap", 32'(wrap), 32'h1);

    // ch2: transfer on its wrap edge
    en = 4'b0100;
    step(1);
    checkOutput("ch2_e1_divided", 32'(divided), 32'h0);
    applyStimulus(2'd2, 16'd3, 1'b1);
    step(1);
    checkOutput("ch2_e2_wrap", 32'(wrap), 32'h4);
    checkOutput("ch2_e2_divided", 32'(divided), 32'h4);
    checkOutput("ch2_e2_pending", 32'(pending), 32'h4);
    cfg_valid = 1'b0;
    step(1);
    checkOutput("ch2_e3_divided", 32'(divided), 32'h0);
    step(1);
    checkOutput("ch2_e4_divided", 32'(divided), 32'h4);
    checkOutput("ch2_e4_pending", 32'(pending), 32'h0);
    step(3);
    checkOutput("ch2_e7_divided", 32'(divided), 32'h0);
    step(1);
    checkOutput("ch2_e8_divided", 32'(divided), 32'h4);
    checkOutput("ch2_e8_wrap", 32'(wrap), 32'h4);

    // ch3: div 0 pulse, then div 0 toggle
    en = 4'b0000;
    applyStimulus(2'd3, 16'd0, 1'b1);
    step(1);
    checkOutput("ch3_load_pending", 32'(pending), 32'h8);
    cfg_valid = 1'b0;
    step(1);
    checkOutput("ch3_apply_pending", 32'(pending), 32'h0);
    en = 4'b1000;
    step(1);
    checkOutput("ch3_p1_divided", 32'(divided), 32'h8);
    checkOutput("ch3_p1_wrap", 32'(wrap), 32'h8);
    step(1);
    checkOutput("ch3_p2_divided", 32'(divided), 32'h8);
    checkOutput("ch3_p2_wrap", 32'(wrap), 32'h8);
    applyStimulus(2'd3, 16'd0, 1'b0);
    step(1);
    checkOutput("ch3_xfer_pending", 32'(pending), 32'h8);
    checkOutput("ch3_xfer_divided", 32'(divided), 32'h8);
    cfg_valid = 1'b0;
    step(1);
    checkOutput("ch3_apply_divided", 32'(divided), 32'h8);
    checkOutput("ch3_apply_pending2", 32'(pending), 32'h0);
    step(1);
    checkOutput("ch3_t1_divided", 32'(divided), 32'h0);
    checkOutput("ch3_t1_wrap", 32'(wrap), 32'h8);
    step(1);
    checkOutput("ch3_t2_divided", 32'(divided), 32'h8);
    step(1);
    checkOutput("ch3_t3_divided", 32'(divided), 32'h0);

    // Asynchronous reset mid-count with a pending shadow
    en = 4'b1111;
    applyStimulus(2'd1, 16'd9, 1'b1);
    step(1);
    checkOutput("pre_rst_divided", 32'(divided), 32'h8);
    checkOutput("pre_rst_pending", 32'(pending), 32'h2);
    cfg_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("async_rst_divided", 32'(divided), 32'h0);
    checkOutput("async_rst_wrap", 32'(wrap), 32'h0);
    checkOutput("async_rst_pending", 32'(pending), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 4'b0001;
    step(1);
    checkOutput("post_rst_e1_divided", 32'(divided), 32'h0);
    step(1);
    checkOutput("post_rst_e2_divided", 32'(divided), 32'h1);
    checkOutput("post_rst_e2_wrap", 32'(wrap), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
